// File: rtl/full_adder_pkg.sv
// Shared constants and helpers for the registered ripple-carry full adder.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    localparam logic [FA_MAX_WIDTH-1:0] FA_RST_VAL = '0;

    // Two's-complement overflow: like-signed operands whose result sign flips.
    function automatic logic fa_signed_ovf(
        input logic aMsb,
        input logic bMsb,
        input logic sumMsb
    );
        return (aMsb == bMsb) && (sumMsb != aMsb);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell; chained on its carry to build the ripple adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with async active-high reset.
// Optional signed-overflow output ovf is built when FULL_ADDER_OVF_EN is defined.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    generate
        if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : gWidthCheck
            $error("full_adder: WIDTH %0d outside legal range 1..%0d", WIDTH, FA_MAX_WIDTH);
        end
    endgenerate

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = cin;

    // carry[i+1] is the carry out of bit i; the final one becomes cout.
    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        full_adder_bit uBit (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_d[i]),
            .co (carry[i+1])
        );
    end

    assign cout_d = carry[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= FA_RST_VAL[WIDTH-1:0];
            cout_q <= FA_RST_VAL[0];
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef FULL_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = fa_signed_ovf(a[WIDTH-1], b[WIDTH-1], sum_d[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= FA_RST_VAL[0];
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: a WIDTH=1 and a WIDTH=8 instance driven in lockstep.
// Define FULL_ADDER_OVF_EN to also check the ovf output.
module tb_full_adder;

    typedef struct {
        string      tag;
        logic       isWide;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } expect_t;

    logic       clk;
    logic       rst;
    logic [0:0] a1, b1;
    logic       cin1;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [0:0] sum1;
    logic       cout1;
    logic [7:0] sum8;
    logic       cout8;
    logic       ovf1, ovf8;

    expect_t sbQ[$];
    int      checks = 0;
    int      errors = 0;

    full_adder #(.WIDTH(1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
        .sum  (sum1),
        .cout (cout1)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf  (ovf1)
`endif
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst  (rst),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .sum  (sum8),
        .cout (cout8)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf  (ovf8)
`endif
    );

`ifndef FULL_ADDER_OVF_EN
    assign ovf1 = 1'b0;
    assign ovf8 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive both instances and queue the results they must show after the next edge.
    task automatic applyStimulus(input string tag,
                                 input logic a1v, input logic b1v, input logic c1v,
                                 input logic [7:0] a8v, input logic [7:0] b8v, input logic c8v);
        logic [1:0] r1;
        logic [8:0] r8;
        expect_t    e;
        a1 = a1v; b1 = b1v; cin1 = c1v;
        a8 = a8v; b8 = b8v; cin8 = c8v;
        r1 = {1'b0, a1v} + {1'b0, b1v} + {1'b0, c1v};
        r8 = {1'b0, a8v} + {1'b0, b8v} + {8'b0, c8v};
        e.tag = {tag, ".w1"}; e.isWide = 1'b0; e.sum = {7'b0, r1[0]}; e.cout = r1[1];
        e.ovf = (a1v == b1v) && (r1[0] != a1v);
        sbQ.push_back(e);
        e.tag = {tag, ".w8"}; e.isWide = 1'b1; e.sum = r8[7:0]; e.cout = r8[8];
        e.ovf = (a8v[7] == b8v[7]) && (r8[7] != a8v[7]);
        sbQ.push_back(e);
    endtask

    task automatic captureAndCompare();
        expect_t e;
        @(posedge clk);
        #1;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            if (e.isWide) begin
                checkOutput({e.tag, ".sum"}, 64'(sum8), 64'(e.sum));
                checkOutput({e.tag, ".cout"}, 64'(cout8), 64'(e.cout));
`ifdef FULL_ADDER_OVF_EN
                checkOutput({e.tag, ".ovf"}, 64'(ovf8), 64'(e.ovf));
`endif
            end else begin
                checkOutput({e.tag, ".sum"}, 64'(sum1), 64'(e.sum));
                checkOutput({e.tag, ".cout"}, 64'(cout1), 64'(e.cout));
`ifdef FULL_ADDER_OVF_EN
                checkOutput({e.tag, ".ovf"}, 64'(ovf1), 64'(e.ovf));
`endif
            end
        end
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".sum1"}, 64'(sum1), 64'd0);
        checkOutput({tag, ".cout1"}, 64'(cout1), 64'd0);
        checkOutput({tag, ".sum8"}, 64'(sum8), 64'd0);
        checkOutput({tag, ".cout8"}, 64'(cout8), 64'd0);
`ifdef FULL_ADDER_OVF_EN
        checkOutput({tag, ".ovf1"}, 64'(ovf1), 64'd0);
        checkOutput({tag, ".ovf8"}, 64'(ovf8), 64'd0);
`endif
    endtask

    initial begin
        // Reset asserted with all-ones inputs, checked before any clock edge.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        #1;
        checkCleared("reset");
        #2;
        rst = 1'b0;
        applyStimulus("rel", 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        captureAndCompare();

        // Exhaustive 1-bit truth table, one operation per cycle.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            applyStimulus($sformatf("tt%0d", i), v[2], v[1], v[0], {5'b0, v}, {5'b0, v}, v[0]);
            captureAndCompare();
        end

        applyStimulus("ffp0c1", 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1);
        captureAndCompare();
        applyStimulus("0fp01", 1'b1, 1'b0, 1'b0, 8'h0F, 8'h01, 1'b0);
        captureAndCompare();
        applyStimulus("zeros", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        captureAndCompare();
        applyStimulus("ovf7f", 1'b0, 1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
        captureAndCompare();
        applyStimulus("ovf80", 1'b1, 1'b1, 1'b0, 8'h80, 8'h80, 1'b0);
        captureAndCompare();

        // Back-to-back operations on consecutive edges.
        applyStimulus("pipeA", 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0);
        captureAndCompare();
        applyStimulus("pipeB", 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
        captureAndCompare();

        for (int i = 0; i < 24; i++) begin
            logic [17:0] r;
            r = 18'($urandom);
            applyStimulus($sformatf("rnd%0d", i), r[0], r[1], r[2], r[10:3], r[17:11], r[2]);
            captureAndCompare();
        end

        // Inputs moving between edges must not reach the outputs.
        applyStimulus("hold", 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        captureAndCompare();
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        #2;
        checkOutput("hold.sum8", 64'(sum8), 64'hFF);
        checkOutput("hold.cout8", 64'(cout8), 64'd1);

        // Mid-stream reset while cout=1, held across an edge, then released.
        #1;
        rst = 1'b1;
        #1;
        checkCleared("midrst");
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b1;
        @(posedge clk);
        #1;
        checkCleared("rsthold");
        #3;
        rst = 1'b0;
        applyStimulus("postrst", 1'b1, 1'b0, 1'b0, 8'hF0, 8'h20, 1'b1);
        captureAndCompare();

        if (sbQ.size() != 0) begin
            checkOutput("sbEmpty", 64'(sbQ.size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
